// File: rtl/obuf_tag_pkg.sv
// Shared definitions for the output-buffer tag handshake.
//   cmd_op_e    : decoder command opcodes (NEW, REUSE, FLUSH, reserved)
//   tag_state_e : per-tag state encodings used by the per-tag obuf tag logic
package obuf_tag_pkg;

  localparam int unsigned CMD_OP_W    = 2;
  localparam int unsigned TAG_STATE_W = 3;

  typedef enum logic [CMD_OP_W-1:0] {
    CMD_NEW   = 2'd0,
    CMD_REUSE = 2'd1,
    CMD_FLUSH = 2'd2,
    CMD_RSVD  = 2'd3
  } cmd_op_e;

  typedef enum logic [TAG_STATE_W-1:0] {
    FREE          = 3'd0,
    LDMEM         = 3'd1,
    COMPUTE       = 3'd2,
    COMPUTE_CHECK = 3'd3,
    STMEM         = 3'd4
  } tag_state_e;

endpackage

// File: rtl/obuf_tag_sequencer_if.sv
// Decoder -> tag sequencer command channel.
//   cmd_valid        : command present
//   cmd_ready        : command accepted when valid & ready
//   cmd_op           : NEW / REUSE / FLUSH / reserved
//   cmd_bias_prev_sw : bias/prev select for NEW or REUSE
//   cmd_ddr_pe_sw    : ddr/pe select for NEW or REUSE
// master = decoder side, slave = sequencer side.
interface obuf_tag_sequencer_if;
  import obuf_tag_pkg::*;

  logic    cmd_valid;
  logic    cmd_ready;
  cmd_op_e cmd_op;
  logic    cmd_bias_prev_sw;
  logic    cmd_ddr_pe_sw;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_bias_prev_sw,
    output cmd_ddr_pe_sw,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_bias_prev_sw,
    input  cmd_ddr_pe_sw,
    output cmd_ready
  );

endinterface

// File: rtl/obuf_tag_ptr.sv
// Modulo-NUM_TAGS wrapping counter with increment enable.
//   clk, reset : clock, synchronous active-high reset (count returns to 0)
//   inc_i      : advance by one, wrapping NUM_TAGS-1 -> 0
//   ptr_o      : current count
module obuf_tag_ptr #(
  parameter int unsigned NUM_TAGS = 2,
  parameter int unsigned TAG_W    = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [TAG_W-1:0] ptr_o
);

  logic [TAG_W-1:0] ptr_q, ptr_d;

  // Explicit wrap so non-power-of-two tag counts work.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      if (ptr_q == TAG_W'(NUM_TAGS - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + TAG_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/obuf_tag_sequencer.sv
// Initiator side of the output-buffer tag handshake.
// Accepts NEW / REUSE / FLUSH commands, allocates tags round-robin, drives per-tag
// request/reuse/flush pulses, tracks the tag owned by each stage and demuxes the stage
// done pulses back to the owning tag.
//   clk, reset             : clock, synchronous active-high reset
//   cmd                    : command channel (slave modport)
//   tag_req/reuse/flush_o  : one-hot single-cycle pulses per tag
//   tag_bias_prev_sw_o,
//   tag_ddr_pe_sw_o        : broadcast side-band, held until the next NEW/REUSE accept
//   tag_ready_i            : per-tag FREE indication
//   next_compute_tag_i     : per-tag compute finished and flushed
//   *_done_i / *_tag_done_o: stage done pulses and their per-tag demux
//   *_tag_o                : tag currently owned by each stage
//   cur_tag_o, cur_valid_o : tag targeted by REUSE/FLUSH and whether it is open
// Build option: OBUF_TAG_SEQ_IMPLICIT_FLUSH_EN lets NEW close the open tag by pulsing
// tag_flush on it alongside tag_req; otherwise NEW stalls until an explicit FLUSH.
module obuf_tag_sequencer
  import obuf_tag_pkg::*;
#(
  parameter int unsigned NUM_TAGS = 2,
  parameter int unsigned TAG_W    = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  obuf_tag_sequencer_if.slave cmd,
  output logic [NUM_TAGS-1:0] tag_req_o,
  output logic [NUM_TAGS-1:0] tag_reuse_o,
  output logic [NUM_TAGS-1:0] tag_flush_o,
  output logic                tag_bias_prev_sw_o,
  output logic                tag_ddr_pe_sw_o,
  input  logic [NUM_TAGS-1:0] tag_ready_i,
  input  logic [NUM_TAGS-1:0] next_compute_tag_i,
  input  logic                ldmem_done_i,
  input  logic                compute_done_i,
  input  logic                stmem_done_i,
  output logic [NUM_TAGS-1:0] ldmem_tag_done_o,
  output logic [NUM_TAGS-1:0] compute_tag_done_o,
  output logic [NUM_TAGS-1:0] stmem_tag_done_o,
  output logic [TAG_W-1:0]    ldmem_tag_o,
  output logic [TAG_W-1:0]    compute_tag_o,
  output logic [TAG_W-1:0]    stmem_tag_o,
  output logic [TAG_W-1:0]    cur_tag_o,
  output logic                cur_valid_o
);

  function automatic logic [NUM_TAGS-1:0] onehot(input logic [TAG_W-1:0] idx);
    return NUM_TAGS'(1) << idx;
  endfunction

  logic [TAG_W-1:0]    alloc_ptr, ldmem_ptr, compute_ptr, stmem_ptr;
  logic [TAG_W-1:0]    cur_tag_q, cur_tag_d;
  logic                cur_valid_q, cur_valid_d;
  logic [NUM_TAGS-1:0] pend_q, pend_d;
  logic [NUM_TAGS-1:0] req_q, req_d, reuse_q, reuse_d, flush_q, flush_d;
  logic                bias_q, bias_d, ddr_q, ddr_d;
  logic                new_ok, accept, new_acc, reuse_acc, flush_acc;

`ifdef OBUF_TAG_SEQ_IMPLICIT_FLUSH_EN
  assign new_ok = 1'b1;
`else
  assign new_ok = ~cur_valid_q;
`endif

  always_comb begin
    cmd.cmd_ready = 1'b1;
    unique case (cmd.cmd_op)
      CMD_NEW:   cmd.cmd_ready = tag_ready_i[alloc_ptr] & ~pend_q[alloc_ptr] & new_ok;
      CMD_REUSE: cmd.cmd_ready = cur_valid_q;
      CMD_FLUSH: cmd.cmd_ready = cur_valid_q;
      CMD_RSVD:  cmd.cmd_ready = 1'b1;
    endcase
  end

  assign accept    = cmd.cmd_valid & cmd.cmd_ready;
  assign new_acc   = accept & (cmd.cmd_op == CMD_NEW);
  assign reuse_acc = accept & (cmd.cmd_op == CMD_REUSE);
  assign flush_acc = accept & (cmd.cmd_op == CMD_FLUSH);

  always_comb begin
    req_d       = '0;
    reuse_d     = '0;
    flush_d     = '0;
    bias_d      = bias_q;
    ddr_d       = ddr_q;
    cur_tag_d   = cur_tag_q;
    cur_valid_d = cur_valid_q;
    // A pending request waits for the tag to leave FREE before it may be reallocated.
    pend_d      = pend_q & tag_ready_i;

    if (new_acc) begin
      req_d       = onehot(alloc_ptr);
      cur_tag_d   = alloc_ptr;
      cur_valid_d = 1'b1;
      pend_d      = pend_d | onehot(alloc_ptr);
`ifdef OBUF_TAG_SEQ_IMPLICIT_FLUSH_EN
      if (cur_valid_q) begin
        flush_d = onehot(cur_tag_q);
      end
`endif
    end
    if (reuse_acc) begin
      reuse_d = onehot(cur_tag_q);
    end
    if (flush_acc) begin
      flush_d     = onehot(cur_tag_q);
      cur_valid_d = 1'b0;
    end
    if (new_acc || reuse_acc) begin
      bias_d = cmd.cmd_bias_prev_sw;
      ddr_d  = cmd.cmd_ddr_pe_sw;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q       <= '0;
      reuse_q     <= '0;
      flush_q     <= '0;
      bias_q      <= 1'b0;
      ddr_q       <= 1'b0;
      cur_tag_q   <= '0;
      cur_valid_q <= 1'b0;
      pend_q      <= '0;
    end else begin
      req_q       <= req_d;
      reuse_q     <= reuse_d;
      flush_q     <= flush_d;
      bias_q      <= bias_d;
      ddr_q       <= ddr_d;
      cur_tag_q   <= cur_tag_d;
      cur_valid_q <= cur_valid_d;
      pend_q      <= pend_d;
    end
  end

  obuf_tag_ptr #(.NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W)) u_alloc_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (new_acc),
    .ptr_o (alloc_ptr)
  );

  obuf_tag_ptr #(.NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W)) u_ldmem_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (ldmem_done_i),
    .ptr_o (ldmem_ptr)
  );

  // Only the tag compute currently owns may hand it on.
  obuf_tag_ptr #(.NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W)) u_compute_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (next_compute_tag_i[compute_ptr]),
    .ptr_o (compute_ptr)
  );

  obuf_tag_ptr #(.NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W)) u_stmem_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (stmem_done_i),
    .ptr_o (stmem_ptr)
  );

  assign tag_req_o          = req_q;
  assign tag_reuse_o        = reuse_q;
  assign tag_flush_o        = flush_q;
  assign tag_bias_prev_sw_o = bias_q;
  assign tag_ddr_pe_sw_o    = ddr_q;

  assign ldmem_tag_done_o   = ldmem_done_i   ? onehot(ldmem_ptr)   : '0;
  assign compute_tag_done_o = compute_done_i ? onehot(compute_ptr) : '0;
  assign stmem_tag_done_o   = stmem_done_i   ? onehot(stmem_ptr)   : '0;

  assign ldmem_tag_o   = ldmem_ptr;
  assign compute_tag_o = compute_ptr;
  assign stmem_tag_o   = stmem_ptr;
  assign cur_tag_o     = cur_tag_q;
  assign cur_valid_o   = cur_valid_q;

endmodule

// File: tb/tb_obuf_tag_sequencer.sv
// Directed bench for obuf_tag_sequencer (NUM_TAGS = 2).
module tb_obuf_tag_sequencer;
  import obuf_tag_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] tag_req, tag_reuse, tag_flush;
  logic       tag_bias_prev_sw, tag_ddr_pe_sw;
  logic [1:0] tag_ready, next_compute_tag;
  logic       ldmem_done, compute_done, stmem_done;
  logic [1:0] ldmem_tag_done, compute_tag_done, stmem_tag_done;
  logic       ldmem_tag, compute_tag, stmem_tag, cur_tag, cur_valid;

  int n_total = 0;
  int n_pass  = 0;

  obuf_tag_sequencer_if bus ();

  obuf_tag_sequencer #(.NUM_TAGS(2), .TAG_W(1)) dut (
    .clk                (clk),
    .reset              (reset),
    .cmd                (bus.slave),
    .tag_req_o          (tag_req),
    .tag_reuse_o        (tag_reuse),
    .tag_flush_o        (tag_flush),
    .tag_bias_prev_sw_o (tag_bias_prev_sw),
    .tag_ddr_pe_sw_o    (tag_ddr_pe_sw),
    .tag_ready_i        (tag_ready),
    .next_compute_tag_i (next_compute_tag),
    .ldmem_done_i       (ldmem_done),
    .compute_done_i     (compute_done),
    .stmem_done_i       (stmem_done),
    .ldmem_tag_done_o   (ldmem_tag_done),
    .compute_tag_done_o (compute_tag_done),
    .stmem_tag_done_o   (stmem_tag_done),
    .ldmem_tag_o        (ldmem_tag),
    .compute_tag_o      (compute_tag),
    .stmem_tag_o        (stmem_tag),
    .cur_tag_o          (cur_tag),
    .cur_valid_o        (cur_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input cmd_op_e op, input logic b, input logic d);
    bus.cmd_valid        = 1'b1;
    bus.cmd_op           = op;
    bus.cmd_bias_prev_sw = b;
    bus.cmd_ddr_pe_sw    = d;
    #1;
  endtask

  task automatic idle();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = CMD_NEW;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset                = 1'b1;
    bus.cmd_valid        = 1'b0;
    bus.cmd_op           = CMD_NEW;
    bus.cmd_bias_prev_sw = 1'b0;
    bus.cmd_ddr_pe_sw    = 1'b0;
    tag_ready            = 2'b00;
    next_compute_tag     = 2'b00;
    ldmem_done           = 1'b0;
    compute_done         = 1'b0;
    stmem_done           = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_req", 32'(tag_req), 32'h0);
    chk("rst_flush", 32'(tag_flush), 32'h0);
    chk("rst_cur_valid", 32'(cur_valid), 32'h0);
    chk("rst_bias", 32'(tag_bias_prev_sw), 32'h0);
    chk("rst_ready_new_busy", 32'(bus.cmd_ready), 32'h0);
    reset = 1'b0;

    // Single NEW
    tag_ready = 2'b11;
    drive(CMD_NEW, 1'b1, 1'b0);
    chk("a_ready", 32'(bus.cmd_ready), 32'h1);
    step();
    idle();
    chk("a_req", 32'(tag_req), 32'h1);
    chk("a_bias", 32'(tag_bias_prev_sw), 32'h1);
    chk("a_ddr", 32'(tag_ddr_pe_sw), 32'h0);
    chk("a_cur_tag", 32'(cur_tag), 32'h0);
    chk("a_cur_valid", 32'(cur_valid), 32'h1);
    step();
    chk("a_req_one_cycle", 32'(tag_req), 32'h0);
    chk("a_bias_held", 32'(tag_bias_prev_sw), 32'h1);

    // NEW, REUSE, REUSE, FLUSH back to back
    do_reset();
    drive(CMD_NEW, 1'b0, 1'b1);
    step();
    drive(CMD_REUSE, 1'b1, 1'b1);
    chk("b_req", 32'(tag_req), 32'h1);
    chk("b_ready_reuse", 32'(bus.cmd_ready), 32'h1);
    step();
    chk("b_reuse1", 32'(tag_reuse), 32'h1);
    chk("b_req_gone", 32'(tag_req), 32'h0);
    chk("b_bias1", 32'(tag_bias_prev_sw), 32'h1);
    drive(CMD_REUSE, 1'b0, 1'b0);
    step();
    chk("b_reuse2", 32'(tag_reuse), 32'h1);
    chk("b_bias2", 32'(tag_bias_prev_sw), 32'h0);
    drive(CMD_FLUSH, 1'b0, 1'b0);
    chk("b_ready_flush", 32'(bus.cmd_ready), 32'h1);
    step();
    chk("b_flush", 32'(tag_flush), 32'h1);
    chk("b_reuse_gone", 32'(tag_reuse), 32'h0);
    chk("b_cur_valid", 32'(cur_valid), 32'h0);
    drive(CMD_REUSE, 1'b0, 1'b0);
    chk("b_ready_reuse_closed", 32'(bus.cmd_ready), 32'h0);
    drive(CMD_RSVD, 1'b0, 1'b0);
    chk("b_ready_rsvd", 32'(bus.cmd_ready), 32'h1);
    step();
    idle();
    chk("b_rsvd_no_flush", 32'(tag_flush), 32'h0);
    chk("b_rsvd_no_reuse", 32'(tag_reuse), 32'h0);

    // Round-robin with tag 0 busy
    do_reset();
    drive(CMD_NEW, 1'b0, 1'b0);
    step();
    tag_ready = 2'b10;
    drive(CMD_FLUSH, 1'b0, 1'b0);
    step();
    drive(CMD_NEW, 1'b0, 1'b0);
    chk("c_ready_new1", 32'(bus.cmd_ready), 32'h1);
    step();
    chk("c_req1", 32'(tag_req), 32'h2);
    chk("c_cur_tag1", 32'(cur_tag), 32'h1);
    drive(CMD_FLUSH, 1'b0, 1'b0);
    step();
    chk("c_flush1", 32'(tag_flush), 32'h2);
    drive(CMD_NEW, 1'b0, 1'b0);
    chk("c_ready_stall", 32'(bus.cmd_ready), 32'h0);
    step();
    chk("c_no_req", 32'(tag_req), 32'h0);
    tag_ready = 2'b11;
    #1;
    chk("c_ready_free", 32'(bus.cmd_ready), 32'h1);
    step();
    idle();
    chk("c_req0", 32'(tag_req), 32'h1);
    chk("c_cur_tag0", 32'(cur_tag), 32'h0);

    // Stage pointers and done demux
    do_reset();
    chk("d_ldmem_tag0", 32'(ldmem_tag), 32'h0);
    ldmem_done = 1'b1;
    #1;
    chk("d_ld_done0", 32'(ldmem_tag_done), 32'h1);
    step();
    chk("d_ldmem_tag1", 32'(ldmem_tag), 32'h1);
    chk("d_ld_done1", 32'(ldmem_tag_done), 32'h2);
    step();
    ldmem_done = 1'b0;
    #1;
    chk("d_ldmem_wrap", 32'(ldmem_tag), 32'h0);
    chk("d_ld_done_idle", 32'(ldmem_tag_done), 32'h0);
    next_compute_tag = 2'b10;
    step();
    chk("d_compute_ignore", 32'(compute_tag), 32'h0);
    next_compute_tag = 2'b01;
    step();
    next_compute_tag = 2'b00;
    chk("d_compute_adv", 32'(compute_tag), 32'h1);
    compute_done = 1'b1;
    stmem_done   = 1'b1;
    #1;
    chk("d_cmp_done", 32'(compute_tag_done), 32'h2);
    chk("d_st_done", 32'(stmem_tag_done), 32'h1);
    step();
    compute_done = 1'b0;
    stmem_done   = 1'b0;
    #1;
    chk("d_stmem_adv", 32'(stmem_tag), 32'h1);
    chk("d_compute_hold", 32'(compute_tag), 32'h1);

    // NEW while a tag is open
    do_reset();
    chk("e_ptr_reset", 32'(stmem_tag), 32'h0);
    drive(CMD_NEW, 1'b0, 1'b0);
    step();
    drive(CMD_NEW, 1'b0, 1'b0);
`ifdef OBUF_TAG_SEQ_IMPLICIT_FLUSH_EN
    chk("e_ready_implicit", 32'(bus.cmd_ready), 32'h1);
    step();
    idle();
    chk("e_req1", 32'(tag_req), 32'h2);
    chk("e_flush0", 32'(tag_flush), 32'h1);
    chk("e_cur_tag", 32'(cur_tag), 32'h1);
    chk("e_cur_valid", 32'(cur_valid), 32'h1);
`else
    chk("e_ready_blocked", 32'(bus.cmd_ready), 32'h0);
    step();
    chk("e_no_req", 32'(tag_req), 32'h0);
    chk("e_cur_tag_hold", 32'(cur_tag), 32'h0);
    drive(CMD_FLUSH, 1'b0, 1'b0);
    step();
    chk("e_flush0", 32'(tag_flush), 32'h1);
    drive(CMD_NEW, 1'b0, 1'b0);
    chk("e_ready_after_flush", 32'(bus.cmd_ready), 32'h1);
    step();
    idle();
    chk("e_req1", 32'(tag_req), 32'h2);
    chk("e_cur_tag", 32'(cur_tag), 32'h1);
`endif

    // Reset mid-operation drops the pending pulse
    drive(CMD_NEW, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    idle();
    chk("f_req_dropped", 32'(tag_req), 32'h0);
    chk("f_cur_valid", 32'(cur_valid), 32'h0);
    chk("f_cur_tag", 32'(cur_tag), 32'h0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/obuf_tag_sequencer.md
# obuf_tag_sequencer

Initiator side of the output-buffer tag handshake. Accepts tile commands from the instruction decoder (new tile, reuse, flush), allocates output-buffer tags round-robin, and drives per-tag `tag_req`/`tag_reuse`/`tag_flush` pulses into the per-tag obuf tag-logic instances. Also tracks which tag each stage (ldmem, compute, stmem) currently owns, and demultiplexes the stage done-pulses back to the owning tag. Sits between the decoder and the array of per-tag state machines.

## Interface
- NUM_TAGS, 2, number of output-buffer tags (≥1)
- TAG_W, 1, index width, equals max(1, clog2(NUM_TAGS))
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  2  0=NEW, 1=REUSE, 2=FLUSH, 3=reserved (accepted, no effect)
- cmd_bias_prev_sw  in  1  bias/prev select for NEW or REUSE
- cmd_ddr_pe_sw  in  1  ddr/pe select for NEW or REUSE
- tag_req, tag_reuse, tag_flush  out  NUM_TAGS  one-hot single-cycle pulses per tag
- tag_bias_prev_sw, tag_ddr_pe_sw  out  1  broadcast; valid with any pulse
- tag_ready  in  NUM_TAGS  per-tag FREE indication
- next_compute_tag  in  NUM_TAGS  per-tag "compute finished and flushed"
- ldmem_done, compute_done, stmem_done  in  1  stage done pulses
- ldmem_tag_done, compute_tag_done, stmem_tag_done  out  NUM_TAGS  demuxed done pulses
- ldmem_tag, compute_tag, stmem_tag  out  TAG_W  tag owned by each stage
- cur_tag  out  TAG_W  tag targeted by REUSE/FLUSH; cur_valid  out  1  cur_tag is open

## Operation
- State: alloc_ptr, cur_tag, cur_valid, ldmem_ptr, compute_ptr, stmem_ptr, pend (NUM_TAGS bits, request issued but tag_ready not yet deasserted).
- cmd_ready (combinational):
  - NEW: tag_ready[alloc_ptr] & ~pend[alloc_ptr].
  - REUSE/FLUSH: cur_valid.
  - Reserved: 1.
- NEW accept: pulse tag_req[alloc_ptr]; cur_tag←alloc_ptr; cur_valid←1; set pend[alloc_ptr]; alloc_ptr←(alloc_ptr+1) mod NUM_TAGS.
- REUSE accept: pulse tag_reuse[cur_tag].
- FLUSH accept: pulse tag_flush[cur_tag]; cur_valid←0.
- pend[i] clears on the first cycle tag_ready[i]=0 after it was set.
- Pointer advance (each wraps NUM_TAGS−1→0):
  - ldmem_ptr on ldmem_done.
  - compute_ptr on next_compute_tag[compute_ptr]; next_compute_tag on any other tag is ignored.
  - stmem_ptr on stmem_done.
- Done demux: X_tag_done = X_done ? onehot(X_ptr) : 0, for X in ldmem, compute, stmem.
- Modulo arithmetic explicit; NUM_TAGS need not be a power of two.

## Timing
- Reset: all outputs 0 and all state 0, except cmd_ready, which follows its combinational rule from state and inputs.
- Handshake at edge N → pulse and side-band sw values asserted during cycle N+1 for exactly one cycle. The output register holds the sw values until the next accept.
- Back-to-back commands are accepted every cycle. REUSE issued the cycle after NEW targets the new tag.
- Done demux and ptr outputs: zero latency, combinational from registered pointers.
- Pointer advance takes effect the cycle after the pulse.
- Simultaneous done pulses on different stages are independent.
- NEW and FLUSH in the same cycle cannot occur (single command port).
- Reset asserted mid-operation: pending pulses are dropped and pointers return to 0 the next cycle.

## Configuration
- OBUF_TAG_SEQ_IMPLICIT_FLUSH_EN defined: NEW while cur_valid=1 is accepted normally (subject to the NEW readiness rule). It also pulses tag_flush[old cur_tag] in the same cycle as tag_req[new tag].
- Not defined: NEW while cur_valid=1 holds cmd_ready=0 until an explicit FLUSH is accepted.

## Structure
- Shared package obuf_tag_pkg:
  - opcode constants CMD_NEW/CMD_REUSE/CMD_FLUSH.
  - tag-state encodings FREE=0, LDMEM=1, COMPUTE=2, COMPUTE_CHECK=3, STMEM=4, width 3.
- Sub-module obuf_tag_ptr: modulo-NUM_TAGS wrapping counter with increment enable. Instantiated four times (alloc, ldmem, compute, stmem).

## Test plan
- Reset; tag_ready=2'b11; NEW with bias=1, ddr=0 → tag_req=2'b01 at N+1 for one cycle, tag_bias_prev_sw=1, cur_tag=0, cur_valid=1.
- NEW, REUSE, REUSE, FLUSH on consecutive cycles → tag_req[0], then tag_reuse[0] twice, then tag_flush[0]; cur_valid=0 after FLUSH.
- Two NEW/FLUSH pairs while tag_ready[0] is held 0 after the first → second NEW to tag 1 accepted. A third NEW stalls (cmd_ready=0) until tag_ready[0]=1.
- ldmem_done ×2, compute_done with compute_ptr=1 → ldmem_tag_done=01 then 10, ldmem_tag wraps to 0, compute_tag_done=2'b10.
- next_compute_tag=2'b10 while compute_ptr=0 → compute_ptr stays 0; then next_compute_tag=2'b01 → compute_ptr=1.
- NEW with cur_valid=1: with macro, tag_req[1] and tag_flush[0] are pulsed together; without macro, cmd_ready=0 until a FLUSH is accepted.
